// File: rtl/radix_pkg.sv
// Shared definitions for the radix-4 multiplier checker: widths, MISR
// polynomial and seed, FSM state encoding and the MISR step function.
package radix_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // Tap mask for x16+x5+x3+x2+1; bit 0 is fed by the rotated-out MSB.
  localparam logic [PROD_W-1:0] SIG_POLY     = 16'h002C;
  localparam logic [PROD_W-1:0] SIG_SEED_DEF = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_COMPARE   = 2'd2,
    ST_FINISHED  = 2'd3
  } state_e;

  // One MISR step: rotate left, fold the MSB into the tap positions,
  // then absorb the data word.
  function automatic logic [PROD_W-1:0] misr_step(input logic [PROD_W-1:0] s,
                                                  input logic [PROD_W-1:0] d);
    logic [PROD_W-1:0] n;
    n = {s[PROD_W-2:0], s[PROD_W-1]};
    if (s[PROD_W-1]) begin
      n = n ^ SIG_POLY;
    end
    return n ^ d;
  endfunction

endpackage

// File: rtl/radix_ref_mult.sv
// Combinational 8x8->16 reference multiplier. Operands are sign- or
// zero-extended to the product width so a single 16-bit multiply yields
// the correct low 16 bits in either mode.
module radix_ref_mult
  import radix_pkg::*;
#(
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;

  // Extend operands per the signedness mode and form the truncated product.
  always_comb begin
    if (SIGNED_MODE) begin
      a_ext = {{(PROD_W-OP_W){a_i[OP_W-1]}}, a_i};
      b_ext = {{(PROD_W-OP_W){b_i[OP_W-1]}}, b_i};
    end else begin
      a_ext = {{(PROD_W-OP_W){1'b0}}, a_i};
      b_ext = {{(PROD_W-OP_W){1'b0}}, b_i};
    end
    p_o = a_ext * b_ext;
  end

endmodule

// File: rtl/radix_checker.sv
// Consumer end of the LFSR test-vector path: captures each operand pair,
// waits for the multiplier's done pulse, checks the product against a
// reference, folds it into a MISR signature and keeps readout counters.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for start_radix; operands captured on launch
// ST_WAIT_DONE | waiting for done_radix; timeout timer running
// ST_COMPARE   | one cycle: check captured product, update counts and MISR
// ST_FINISHED  | N_VECTORS products logged; everything frozen until reset
module radix_checker
  import radix_pkg::*;
#(
  parameter int                N_VECTORS   = 256,
  parameter int                TIMEOUT     = 64,
  parameter bit                SIGNED_MODE = 1'b1,
  parameter logic [PROD_W-1:0] SIG_SEED    = SIG_SEED_DEF
) (
  input  logic                clk,
  input  logic                reset_checker,
  input  logic [OP_W-1:0]     x,
  input  logic [OP_W-1:0]     y,
  input  logic                start_radix,
  input  logic                done_radix,
  input  logic [PROD_W-1:0]   result,
  output logic                busy,
  output logic                test_done,
  output logic                pass,
  output logic [15:0]         error_count,
  output logic [7:0]          timeout_count,
  output logic [15:0]         vector_count,
  output logic [PROD_W-1:0]   signature,
  output logic [31:0]         first_fail
);

  localparam int            TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [15:0]   LAST_VEC = 16'(N_VECTORS - 1);

  state_e              state_q;
  logic [OP_W-1:0]     x_l_q;
  logic [OP_W-1:0]     y_l_q;
  logic [PROD_W-1:0]   res_l_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [15:0]         error_count_q;
  logic [7:0]          timeout_count_q;
  logic [15:0]         vector_count_q;
  logic [PROD_W-1:0]   signature_q;
  logic [31:0]         first_fail_q;
  logic                busy_q;
  logic                test_done_q;
  logic                pass_q;

  logic [PROD_W-1:0]   exp_d;
  logic                mismatch_d;
  logic                last_vec_d;
  logic [PROD_W-1:0]   sig_cmp_d;
  logic [PROD_W-1:0]   sig_to_d;
  logic [15:0]         vector_inc_d;
  logic [15:0]         error_inc_d;
  logic [7:0]          timeout_inc_d;

  radix_ref_mult #(
    .SIGNED_MODE(SIGNED_MODE)
  ) u_ref_mult (
    .a_i(x_l_q),
    .b_i(y_l_q),
    .p_o(exp_d)
  );

  // Compare result, next signatures and saturating increments for the FSM.
  always_comb begin
    mismatch_d    = (res_l_q != exp_d);
    last_vec_d    = (vector_count_q == LAST_VEC);
    sig_cmp_d     = misr_step(signature_q, res_l_q);
    sig_to_d      = misr_step(signature_q, '0);
    vector_inc_d  = (vector_count_q  == 16'hFFFF) ? vector_count_q  : vector_count_q  + 16'd1;
    error_inc_d   = (error_count_q   == 16'hFFFF) ? error_count_q   : error_count_q   + 16'd1;
    timeout_inc_d = (timeout_count_q == 8'hFF)    ? timeout_count_q : timeout_count_q + 8'd1;
  end

  // Checker FSM with counters, MISR and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset_checker) begin
      state_q         <= ST_IDLE;
      x_l_q           <= '0;
      y_l_q           <= '0;
      res_l_q         <= '0;
      tmr_q           <= '0;
      error_count_q   <= '0;
      timeout_count_q <= '0;
      vector_count_q  <= '0;
      signature_q     <= SIG_SEED;
      first_fail_q    <= '0;
      busy_q          <= 1'b0;
      test_done_q     <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_radix) begin
            x_l_q   <= x;
            y_l_q   <= y;
            tmr_q   <= TMR_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          // done on the expiry cycle takes priority over the timeout
          if (done_radix) begin
            res_l_q <= result;
            state_q <= ST_COMPARE;
          end else if (tmr_q == '0) begin
            timeout_count_q <= timeout_inc_d;
            vector_count_q  <= vector_inc_d;
            signature_q     <= sig_to_d;
            busy_q          <= 1'b0;
            if (last_vec_d) begin
              state_q     <= ST_FINISHED;
              test_done_q <= 1'b1;
              pass_q      <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        ST_COMPARE: begin
          if (mismatch_d) begin
            error_count_q <= error_inc_d;
            if (error_count_q == '0) begin
              first_fail_q <= {x_l_q, y_l_q, res_l_q};
            end
          end
          vector_count_q <= vector_inc_d;
          signature_q    <= sig_cmp_d;
          busy_q         <= 1'b0;
          if (last_vec_d) begin
            state_q     <= ST_FINISHED;
            test_done_q <= 1'b1;
            pass_q      <= !mismatch_d && (error_count_q == '0) && (timeout_count_q == '0);
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_FINISHED: begin
          state_q <= ST_FINISHED;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign test_done     = test_done_q;
  assign pass          = pass_q;
  assign error_count   = error_count_q;
  assign timeout_count = timeout_count_q;
  assign vector_count  = vector_count_q;
  assign signature     = signature_q;
  assign first_fail    = first_fail_q;

endmodule

// File: tb/tb_radix_checker.sv
// Directed bench for radix_checker: a signed and an unsigned instance share
// the stimulus; a vector table covers single products, hand-written
// sequences cover timeout, reset and completion corners.
module tb_radix_checker;

  logic        clk = 1'b0;
  logic        reset_checker = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        start_radix = 1'b0;
  logic        done_radix = 1'b0;
  logic [15:0] result = '0;

  logic        a_busy, a_test_done, a_pass;
  logic [15:0] a_err, a_vc, a_sig;
  logic [7:0]  a_to;
  logic [31:0] a_ff;
  logic        b_busy, b_test_done, b_pass;
  logic [15:0] b_err, b_vc, b_sig;
  logic [7:0]  b_to;
  logic [31:0] b_ff;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  radix_checker #(.N_VECTORS(4), .TIMEOUT(8), .SIGNED_MODE(1'b1), .SIG_SEED(16'h8000)) dut_s (
    .clk(clk), .reset_checker(reset_checker), .x(x), .y(y),
    .start_radix(start_radix), .done_radix(done_radix), .result(result),
    .busy(a_busy), .test_done(a_test_done), .pass(a_pass),
    .error_count(a_err), .timeout_count(a_to), .vector_count(a_vc),
    .signature(a_sig), .first_fail(a_ff)
  );

  radix_checker #(.N_VECTORS(4), .TIMEOUT(8), .SIGNED_MODE(1'b0), .SIG_SEED(16'h8000)) dut_u (
    .clk(clk), .reset_checker(reset_checker), .x(x), .y(y),
    .start_radix(start_radix), .done_radix(done_radix), .result(result),
    .busy(b_busy), .test_done(b_test_done), .pass(b_pass),
    .error_count(b_err), .timeout_count(b_to), .vector_count(b_vc),
    .signature(b_sig), .first_fail(b_ff)
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] r;
    bit          err_s;
    bit          err_u;
  } vec_t;

  vec_t tbl[6];

  // Independent bit-level MISR model written from the tap equations.
  function automatic logic [15:0] msr_ref(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] n;
    n[0] = s[15];
    n[1] = s[0];
    n[2] = s[1] ^ s[15];
    n[3] = s[2] ^ s[15];
    n[4] = s[3];
    n[5] = s[4] ^ s[15];
    for (int i = 6; i < 16; i++) n[i] = s[i-1];
    return n ^ d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_checker = 1'b1; start_radix = 1'b0; done_radix = 1'b0;
    @(posedge clk); #1;
    reset_checker = 1'b0;
  endtask

  task automatic launch(input logic [7:0] xv, input logic [7:0] yv);
    @(posedge clk); #1;
    x = xv; y = yv; start_radix = 1'b1;
    @(posedge clk); #1;
    start_radix = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] r);
    done_radix = 1'b1; result = r;
    @(posedge clk); #1;
    done_radix = 1'b0;
  endtask

  task automatic do_vec(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] r);
    launch(xv, yv);
    pulse_done(r);
    @(posedge clk); #1;
  endtask

  logic [15:0] esig;

  initial begin
    tbl[0] = '{8'h03, 8'h05, 16'h000F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h02, 16'hFFFE, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h02, 16'h01FE, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h10, 16'h0101, 1'b1, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 16'h4000, 1'b0, 1'b0};
    tbl[5] = '{8'h7F, 8'h81, 16'hC0FF, 1'b0, 1'b1};

    // reset state
    do_reset();
    chk("rst_busy", a_busy, 0);
    chk("rst_test_done", a_test_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_err", a_err, 0);
    chk("rst_to", a_to, 0);
    chk("rst_vc", a_vc, 0);
    chk("rst_sig", a_sig, 16'h8000);
    chk("rst_ff", a_ff, 0);

    // single-product table, fresh reset per entry
    for (int i = 0; i < 6; i++) begin
      do_reset();
      do_vec(tbl[i].x, tbl[i].y, tbl[i].r);
      chk($sformatf("tbl%0d_s_err", i), a_err, {15'd0, tbl[i].err_s});
      chk($sformatf("tbl%0d_s_ff", i), a_ff, tbl[i].err_s ? {tbl[i].x, tbl[i].y, tbl[i].r} : 32'd0);
      chk($sformatf("tbl%0d_s_vc", i), a_vc, 1);
      chk($sformatf("tbl%0d_s_sig", i), a_sig, msr_ref(16'h8000, tbl[i].r));
      chk($sformatf("tbl%0d_u_err", i), b_err, {15'd0, tbl[i].err_u});
      chk($sformatf("tbl%0d_u_ff", i), b_ff, tbl[i].err_u ? {tbl[i].x, tbl[i].y, tbl[i].r} : 32'd0);
      chk($sformatf("tbl%0d_u_sig", i), b_sig, msr_ref(16'h8000, tbl[i].r));
      chk($sformatf("tbl%0d_busy", i), a_busy, 0);
      if (i == 0) chk("seed_sig", a_sig, 16'h0022);
    end

    // second mismatch keeps the first capture
    do_reset();
    do_vec(8'h10, 8'h10, 16'h0101);
    do_vec(8'h02, 8'h03, 16'h0007);
    chk("mm2_err", a_err, 2);
    chk("mm2_ff", a_ff, 32'h1010_0101);
    chk("mm2_vc", a_vc, 2);
    chk("mm2_test_done", a_test_done, 0);

    // timeout: no done for TIMEOUT cycles
    do_reset();
    launch(8'h03, 8'h05);
    repeat (7) @(posedge clk);
    #1;
    chk("to_busy_pre", a_busy, 1);
    chk("to_cnt_pre", a_to, 0);
    @(posedge clk); #1;
    chk("to_cnt", a_to, 1);
    chk("to_vc", a_vc, 1);
    chk("to_busy", a_busy, 0);
    chk("to_sig", a_sig, msr_ref(16'h8000, 16'h0000));
    esig = msr_ref(msr_ref(16'h8000, 16'h0000), 16'h000F);
    do_vec(8'h03, 8'h05, 16'h000F);
    chk("to_next_vc", a_vc, 2);
    chk("to_next_sig", a_sig, esig);
    chk("to_next_err", a_err, 0);
    chk("to_next_to", a_to, 1);

    // done arriving on the expiry cycle wins
    do_reset();
    launch(8'h03, 8'h05);
    repeat (7) @(posedge clk);
    #1;
    pulse_done(16'h000F);
    @(posedge clk); #1;
    chk("exp_done_to", a_to, 0);
    chk("exp_done_vc", a_vc, 1);
    chk("exp_done_err", a_err, 0);
    chk("exp_done_sig", a_sig, 16'h0022);

    // reset in WAIT_DONE, then a late done
    do_reset();
    do_vec(8'h10, 8'h10, 16'h0101);
    launch(8'h03, 8'h05);
    @(posedge clk); #1;
    chk("midrst_busy_pre", a_busy, 1);
    reset_checker = 1'b1;
    @(posedge clk); #1;
    reset_checker = 1'b0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_vc", a_vc, 0);
    chk("midrst_err", a_err, 0);
    chk("midrst_sig", a_sig, 16'h8000);
    chk("midrst_ff", a_ff, 0);
    pulse_done(16'h000F);
    @(posedge clk); #1;
    chk("late_done_vc", a_vc, 0);
    chk("late_done_sig", a_sig, 16'h8000);
    chk("late_done_busy", a_busy, 0);

    // completion after 4 products
    do_reset();
    esig = 16'h8000;
    do_vec(8'h03, 8'h05, 16'h000F); esig = msr_ref(esig, 16'h000F);
    do_vec(8'h80, 8'h80, 16'h4000); esig = msr_ref(esig, 16'h4000);
    do_vec(8'hFF, 8'h02, 16'hFFFE); esig = msr_ref(esig, 16'hFFFE);
    chk("cmp3_test_done", a_test_done, 0);
    chk("cmp3_pass", a_pass, 0);
    do_vec(8'h00, 8'h55, 16'h0000); esig = msr_ref(esig, 16'h0000);
    chk("cmp_s_test_done", a_test_done, 1);
    chk("cmp_s_pass", a_pass, 1);
    chk("cmp_s_vc", a_vc, 4);
    chk("cmp_s_sig", a_sig, esig);
    chk("cmp_s_busy", a_busy, 0);
    chk("cmp_u_test_done", b_test_done, 1);
    chk("cmp_u_pass", b_pass, 0);
    chk("cmp_u_err", b_err, 1);
    chk("cmp_u_ff", b_ff, 32'hFF02_FFFE);
    do_vec(8'h11, 8'h22, 16'h1234);
    pulse_done(16'hBEEF);
    @(posedge clk); #1;
    chk("fin_vc", a_vc, 4);
    chk("fin_sig", a_sig, esig);
    chk("fin_err", a_err, 0);
    chk("fin_test_done", a_test_done, 1);
    chk("fin_pass", a_pass, 1);
    chk("fin_busy", a_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
